// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register driving a combinational instruction ROM.
// Fetched {instr, pc} pairs go to decode through a 2-entry valid/ready buffer.
module instr_fetch_unit #(
    parameter int          Nloc    = 64,
    parameter int          Dbits   = 32,
    parameter logic [31:0] BASE_PC = 32'h0040_0000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic [$clog2(Nloc)-1:0] imem_addr,
    input  logic [Dbits-1:0]        imem_data,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [Dbits-1:0]        out_instr,
    output logic [31:0]             out_pc,
    output logic                    fault,
    output logic [1:0]              fault_code,
    output logic [31:0]             fault_pc,
    output logic [15:0]             retired_cnt
);

    localparam int          AW        = $clog2(Nloc);
    localparam logic [31:0] ROM_BYTES = 32'(Nloc * 4);

    typedef enum logic [0:0] {RUN = 1'b0, FAULT = 1'b1} state_t;

    state_t           state;
    logic [31:0]      pc;
    logic             e1_valid;
    logic [Dbits-1:0] e1_instr;
    logic [31:0]      e1_pc;

    logic [31:0] pc_off;
    logic        in_range;
    logic        pop;
    logic        space;
    logic        redirect_bad;
    logic        redirect_ok;
    logic        range_fault;
    logic        push;
    logic [1:0]  count;
    logic [1:0]  rem;

    assign imem_addr = pc_off[AW+1:2];

    // Per-cycle fetch decisions; the head entry lives in out_*, the second in e1_*.
    always_comb begin
        pc_off       = pc - BASE_PC;
        in_range     = (pc_off < ROM_BYTES);
        pop          = out_valid && out_ready;
        count        = {1'b0, out_valid} + {1'b0, e1_valid};
        space        = (count < 2'd2) || pop;
        redirect_bad = (state == RUN) && redirect_valid && (redirect_pc[1:0] != 2'b00);
        redirect_ok  = (state == RUN) && redirect_valid && (redirect_pc[1:0] == 2'b00);
        range_fault  = (state == RUN) && !redirect_valid && !in_range;
        push         = (state == RUN) && !redirect_valid && in_range && space;
        rem          = count - {1'b0, pop};
    end

    // PC, fault state, retire counter and output buffer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RUN;
            pc          <= BASE_PC;
            out_valid   <= 1'b0;
            out_instr   <= {Dbits{1'b0}};
            out_pc      <= 32'd0;
            e1_valid    <= 1'b0;
            e1_instr    <= {Dbits{1'b0}};
            e1_pc       <= 32'd0;
            fault       <= 1'b0;
            fault_code  <= 2'b00;
            fault_pc    <= 32'd0;
            retired_cnt <= 16'd0;
        end else begin
            if (pop) begin
                retired_cnt <= retired_cnt + 16'd1;
            end

            case (state)
                RUN: begin
                    if (redirect_bad) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= 2'b01;
                        fault_pc   <= redirect_pc;
                    end else if (redirect_ok) begin
                        pc <= redirect_pc;
                    end else if (range_fault) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= 2'b10;
                        fault_pc   <= pc;
                    end else if (push) begin
                        pc <= pc + 32'd4;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= FAULT;
                end
            endcase

            if (redirect_bad || redirect_ok) begin
                // Flush; out_instr/out_pc keep their last value.
                out_valid <= 1'b0;
                e1_valid  <= 1'b0;
            end else begin
                if (pop) begin
                    out_valid <= e1_valid;
                    e1_valid  <= 1'b0;
                    if (e1_valid) begin
                        out_instr <= e1_instr;
                        out_pc    <= e1_pc;
                    end
                end
                if (push) begin
                    case (rem)
                        2'd0: begin
                            out_valid <= 1'b1;
                            out_instr <= imem_data;
                            out_pc    <= pc;
                        end
                        2'd1: begin
                            e1_valid <= 1'b1;
                            e1_instr <= imem_data;
                            e1_pc    <= pc;
                        end
                        default: begin
                            e1_valid <= e1_valid;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: ROM word k holds k; a monitor checks every
// handshake against a queue of expected {instr, pc} filled by the directed stimulus.
module tb_instr_fetch_unit;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] fault_pc;
    logic [15:0] retired_cnt;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    instr_fetch_unit #(.Nloc(64), .Dbits(32), .BASE_PC(BASE)) dut (
        .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .fault(fault), .fault_code(fault_code), .fault_pc(fault_pc), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    assign imem_data = 32'(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_words(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            exp_q.push_back({32'(k), BASE + 32'(k * 4)});
        end
    endtask

    // Monitor: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_handshake_pc", out_pc, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("sb_instr", out_instr, e[63:32]);
                chk("sb_pc", out_pc, e[31:0]);
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = BASE + 32'h40;
        out_ready      = 1'b1;

        // T1: reset held with a pending redirect
        step(3);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_retired", 32'(retired_cnt), 32'd0);

        // T2: streaming with decode always ready
        redirect_valid = 1'b0;
        reset_n        = 1'b1;
        expect_words(0, 10);
        step(12);
        out_ready = 1'b0;
        chk("stream_retired", 32'(retired_cnt), 32'd11);

        // T3: backpressure saturates the buffer, then resumes in order
        expect_words(11, 16);
        step(4);
        chk("bp_imem_addr_hold", 32'(imem_addr), 32'd13);
        chk("bp_head_hold", out_instr, 32'd11);
        chk("bp_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step(6);

        // T4: redirect with a full buffer discards both entries
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = BASE + 32'h20;
        step(1);
        redirect_valid = 1'b0;
        chk("redir_flush_valid", 32'(out_valid), 32'd0);
        chk("redir_imem_addr", 32'(imem_addr), 32'd8);
        out_ready = 1'b1;
        expect_words(8, 11);
        step(5);
        out_ready = 1'b0;
        chk("redir_retired", 32'(retired_cnt), 32'd21);

        // T5: misaligned redirect faults and sticks
        redirect_valid = 1'b1;
        redirect_pc    = BASE + 32'h22;
        step(1);
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_code", 32'(fault_code), 32'd1);
        chk("mis_fault_pc", fault_pc, BASE + 32'h22);
        chk("mis_out_valid", 32'(out_valid), 32'd0);
        redirect_pc = BASE;
        out_ready   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("mis_sticky_fault", 32'(fault), 32'd1);
            chk("mis_sticky_valid", 32'(out_valid), 32'd0);
        end
        chk("mis_code_kept", 32'(fault_code), 32'd1);
        chk("mis_pc_unchanged", 32'(imem_addr), 32'd13);

        // T6: reset out of fault, then run off the end of the ROM
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        step(2);
        chk("rst2_fault", 32'(fault), 32'd0);
        chk("rst2_code", 32'(fault_code), 32'd0);
        chk("rst2_retired", 32'(retired_cnt), 32'd0);
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = BASE + 32'hF8;
        reset_n        = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        step(3);
        chk("end_fault", 32'(fault), 32'd1);
        chk("end_code", 32'(fault_code), 32'd2);
        chk("end_fault_pc", fault_pc, BASE + 32'h100);
        chk("end_head_instr", out_instr, 32'd62);
        chk("end_head_valid", 32'(out_valid), 32'd1);
        expect_words(62, 63);
        out_ready = 1'b1;
        step(3);
        chk("end_drained", 32'(out_valid), 32'd0);
        chk("end_retired", 32'(retired_cnt), 32'd2);

        // Clean restart after reset
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        expect_words(0, 4);
        step(6);
        out_ready = 1'b0;
        chk("restart_retired", 32'(retired_cnt), 32'd5);
        chk("restart_fault", 32'(fault), 32'd0);
        step(2);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
